// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard/redirect/divider inputs toward the
// sequencer, and the per-stage enables, flushes and status it returns.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             load_use_hazard;
  logic             branch_taken;
  logic             md_req;
  logic             md_done;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             md_start;
  logic             md_busy;
  logic             md_abort;
  logic             md_error;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: raises hazards and divide handshake, consumes controls.
  modport master (
    output load_use_hazard, branch_taken, md_req, md_done,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en,
    input  if_id_flush, id_ex_flush, ex_mem_flush,
    input  md_start, md_busy, md_abort, md_error, stall_cycles
  );

  // Sequencer side.
  modport slave (
    input  load_use_hazard, branch_taken, md_req, md_done,
    output pc_en, if_id_en, id_ex_en, ex_mem_en,
    output if_id_flush, id_ex_flush, ex_mem_flush,
    output md_start, md_busy, md_abort, md_error, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges load-use,
// branch redirect and divide-unit handshake into stage enables/bubbles,
// with a saturating stall counter and a divider watchdog.
module pipeline_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic           clk,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
);
  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam int              WAIT_W    = $clog2(MD_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  state_t           state;
  logic [WAIT_W-1:0] wait_cnt;
  logic             md_busy_q;
  logic             md_error_q;
  logic [CNT_W-1:0] stall_q;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush;
  logic md_start, md_abort, md_release;

  // Zero-latency stage controls from current state and hazard inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_start     = 1'b0;
    md_abort     = 1'b0;
    md_release   = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (bus.md_req) begin
            // Hold front end, push a bubble behind the divide.
            md_start     = 1'b1;
            ex_mem_en    = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (bus.branch_taken) begin
            // Squash wrong-path IF/ID and ID/EX; any load-use there dies too.
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (bus.load_use_hazard) begin
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
          end
        end
        MD_WAIT: begin
          // md_req, load_use_hazard and branch_taken are don't-care here.
          if (bus.md_done || wait_cnt == WAIT_LAST) begin
            // Release: result (or garbage on timeout) advances to EX/MEM.
            md_release = 1'b1;
            md_abort   = !bus.md_done;
            pc_en      = 1'b1;
            if_id_en   = 1'b1;
            id_ex_en   = 1'b1;
            ex_mem_en  = 1'b1;
          end else begin
            ex_mem_en    = 1'b1;
            ex_mem_flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, wait counter, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it is just the highest-priority branch on the clock edge.
    if (reset) begin
      state      <= RUN;
      wait_cnt   <= '0;
      md_busy_q  <= 1'b0;
      md_error_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      if (!pc_en && stall_q != {CNT_W{1'b1}})
        stall_q <= stall_q + CNT_W'(1);
      case (state)
        RUN: begin
          if (md_start) begin
            state     <= MD_WAIT;
            wait_cnt  <= '0;
            md_busy_q <= 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_release) begin
            state     <= RUN;
            md_busy_q <= 1'b0;
            if (md_abort)
              md_error_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.md_start     = md_start;
  assign bus.md_abort     = md_abort;
  assign bus.md_busy      = md_busy_q;
  assign bus.md_error     = md_error_q;
  assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected outputs are queued as each
// cycle's stimulus is applied, then popped and compared mid-cycle.
module tb_pipeline_ctrl;
  localparam int TO    = 40;
  localparam int SAT_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(32))    bus ();
  pipeline_ctrl_if #(.CNT_W(SAT_W)) sat_bus ();

  assign sat_bus.load_use_hazard = bus.load_use_hazard;
  assign sat_bus.branch_taken    = bus.branch_taken;
  assign sat_bus.md_req          = bus.md_req;
  assign sat_bus.md_done         = bus.md_done;

  pipeline_ctrl #(.MD_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Narrow stall counter so saturation is reachable in a short run.
  pipeline_ctrl #(.MD_TIMEOUT(TO), .CNT_W(SAT_W)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sat_bus.slave)
  );

  typedef struct {
    string            tag;
    logic [3:0]       en;     // {pc, if_id, id_ex, ex_mem}
    logic [2:0]       fl;     // {if_id, id_ex, ex_mem}
    logic             start;
    logic             abort;
    logic             busy;
    logic             err;
    logic [31:0]      stalls;
    logic [SAT_W-1:0] sat;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state (what the registers should hold right now).
  bit          m_wait;
  int          m_cnt;
  bit          m_err;
  logic [31:0] m_stall;
  int          m_sat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait  = 1'b0;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_stall = '0;
    m_sat   = 0;
  endtask

  // One clock cycle: drive, queue expectation, compare at negedge, advance model.
  task automatic cycle(input string tag, input logic rst, input logic lu,
                       input logic br, input logic req, input logic done);
    exp_t e;
    exp_t g;
    reset               = rst;
    bus.load_use_hazard = lu;
    bus.branch_taken    = br;
    bus.md_req          = req;
    bus.md_done         = done;

    e.tag   = tag;
    e.en    = 4'b0000;
    e.fl    = 3'b000;
    e.start = 1'b0;
    e.abort = 1'b0;
    if (!rst) begin
      if (!m_wait) begin
        if (req)     begin e.start = 1'b1; e.en = 4'b0001; e.fl = 3'b001; end
        else if (br) begin e.en = 4'b1111; e.fl = 3'b110; end
        else if (lu) begin e.en = 4'b0011; e.fl = 3'b010; end
        else               e.en = 4'b1111;
      end else if (done)          e.en = 4'b1111;
      else if (m_cnt == TO - 1)   begin e.en = 4'b1111; e.abort = 1'b1; end
      else                        begin e.en = 4'b0001; e.fl = 3'b001; end
    end
    e.busy   = m_wait;
    e.err    = m_err;
    e.stalls = m_stall;
    e.sat    = SAT_W'(m_sat);
    sb.push_back(e);

    @(negedge clk);
    g = sb.pop_front();
    check({g.tag, ".en"},     {28'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en}, {28'd0, g.en});
    check({g.tag, ".flush"},  {29'd0, bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}, {29'd0, g.fl});
    check({g.tag, ".start"},  {31'd0, bus.md_start}, {31'd0, g.start});
    check({g.tag, ".abort"},  {31'd0, bus.md_abort}, {31'd0, g.abort});
    check({g.tag, ".busy"},   {31'd0, bus.md_busy},  {31'd0, g.busy});
    check({g.tag, ".error"},  {31'd0, bus.md_error}, {31'd0, g.err});
    check({g.tag, ".stalls"}, bus.stall_cycles, g.stalls);
    check({g.tag, ".sat"},    {28'd0, sat_bus.stall_cycles}, {28'd0, g.sat});

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (!e.en[3]) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (m_sat < (1 << SAT_W) - 1) m_sat++;
      end
      if (!m_wait) begin
        if (req) begin m_wait = 1'b1; m_cnt = 0; end
      end else if (done || e.abort) begin
        m_wait = 1'b0;
        if (e.abort) m_err = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset               = 1'b1;
    bus.load_use_hazard = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.md_req          = 1'b0;
    bus.md_done         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset cycle: every control output held low.
    cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Plain flow.
    for (int i = 0; i < 10; i++) cycle("plain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("plain.stall_total", bus.stall_cycles, 32'd0);

    // Single-cycle load-use stall.
    cycle("load_use", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("after_lu", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("load_use.stall_total", bus.stall_cycles, 32'd1);

    // Branch outranks load-use: squash, no stall.
    cycle("br_lu", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("br_lu.stall_total", bus.stall_cycles, 32'd1);

    // Spurious md_done in RUN is ignored.
    cycle("spurious_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Divide: request at cycle 5, done at cycle 38.
    for (int c = 1; c <= 4; c++) cycle("div_pre", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 5; c <= 37; c++) cycle("div_wait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("div_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("div.busy_after_release", {31'd0, bus.md_busy}, 32'd0);
    check("div.stall_total", bus.stall_cycles, 32'd34);
    check("div.sat_stall", {28'd0, sat_bus.stall_cycles}, 32'd15);
    cycle("div_post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back divides with md_req held across release.
    cycle("b2b_start1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle("b2b_wait1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("b2b_release", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle("b2b_start2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle("b2b_wait2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("b2b_done2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle("b2b_post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Watchdog: no md_done, abort on the 40th wait cycle.
    cycle("wd_start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TO - 1; i++) cycle("wd_wait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("wd_abort", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("wd.error_set", {31'd0, bus.md_error}, 32'd1);
    check("wd.back_to_run", {31'd0, bus.md_busy}, 32'd0);
    cycle("wd_post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("wd_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wd.error_cleared", {31'd0, bus.md_error}, 32'd0);
    check("wd.stalls_cleared", bus.stall_cycles, 32'd0);

    // Reset asserted mid-wait: no abort, busy drops after the edge.
    cycle("mid_start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle("mid_wait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("mid_reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mid.busy_cleared", {31'd0, bus.md_busy}, 32'd0);
    cycle("mid_post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("mid_post_lu", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("mid_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
